// File: rtl/collision_matrix_pkg.sv
// collision_pkg: pair enumeration helpers shared by the collision matrix,
// its bus interface and the per-pair trackers. Pairs (i,j), i<j, are
// numbered row-major: (0,1)=0, (0,2)=1, ..., (0,N-1), (1,2), ...
package collision_pkg;

  localparam int MAX_OBJ   = 8;
  localparam int MAX_PAIRS = MAX_OBJ * (MAX_OBJ - 1) / 2;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Row i starts after i*n - i*(i+1)/2 earlier pairs.
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int pair_first(input int k, input int n);
    int idx;
    int res;
    idx = 0;
    res = 0;
    for (int i = 0; i < n - 1; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (idx == k) res = i;
        idx++;
      end
    end
    return res;
  endfunction

  function automatic int pair_second(input int k, input int n);
    int idx;
    int res;
    idx = 0;
    res = 0;
    for (int i = 0; i < n - 1; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (idx == k) res = j;
        idx++;
      end
    end
    return res;
  endfunction

  // Bit k set when object obj is one of the two members of pair k.
  function automatic logic [MAX_PAIRS-1:0] obj_pair_mask(input int obj, input int n);
    logic [MAX_PAIRS-1:0] m;
    m = '0;
    for (int k = 0; k < num_pairs(n); k++) begin
      if (pair_first(k, n) == obj || pair_second(k, n) == obj) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/collision_matrix_if.sv
// collision_matrix_if: draw-request bus plus collision results.
// master = renderer/game-logic side, slave = collision_matrix.
interface collision_matrix_if
  import collision_pkg::*;
#(
  parameter int NUM_OBJ     = 4,
  parameter int COUNT_WIDTH = 8
);

  localparam int NUM_PAIRS = num_pairs(NUM_OBJ);

  logic                           startOfFrame;
  logic [NUM_OBJ-1:0]             draw_requests;
  logic [NUM_PAIRS-1:0]           pair_mask;
  logic                           clear_counts;
  logic                           collision;
  logic [NUM_PAIRS-1:0]           hit_pulse;
  logic [NUM_PAIRS-1:0]           hit_frame;
  logic [NUM_OBJ*COUNT_WIDTH-1:0] obj_hit_count;

  modport master (
    output startOfFrame, draw_requests, pair_mask, clear_counts,
    input  collision, hit_pulse, hit_frame, obj_hit_count
  );

  modport slave (
    input  startOfFrame, draw_requests, pair_mask, clear_counts,
    output collision, hit_pulse, hit_frame, obj_hit_count
  );

endinterface

// File: rtl/collision_matrix_pair_tracker.sv
// collision_pair_tracker: per-pair frame bookkeeping. Keeps the sticky
// "already hit this frame" flag, emits one pulse on the first overlap of a
// frame and publishes the ending frame's flag at each startOfFrame.
module collision_pair_tracker (
  input  logic clk,
  input  logic rst,
  input  logic startOfFrame,
  input  logic ov,
  output logic hit_pulse,
  output logic hit_frame,
  output logic seen
);

  // A startOfFrame cycle begins a new frame, so the old sticky flag must not
  // suppress an overlap that lands on that cycle.
  logic seen_eff;
  assign seen_eff = seen & ~startOfFrame;

  // Sticky flag, first-hit pulse and per-frame publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen      <= 1'b0;
      hit_pulse <= 1'b0;
      hit_frame <= 1'b0;
    end else begin
      hit_pulse <= ov & ~seen_eff;
      if (startOfFrame) begin
        hit_frame <= seen;
        seen      <= ov;
      end else begin
        seen      <= seen | ov;
      end
    end
  end

endmodule

// File: rtl/collision_matrix.sv
// collision_matrix: checks every unordered pair of draw-request channels
// for pixel overlap each clock. Produces a registered any-collision flag,
// per-pair first-hit pulses and per-pair last-frame hit flags.
// Optional build macro COLLISION_COUNT_EN adds per-object saturating
// counters of frames in which the object took part in a hit; without it
// obj_hit_count is tied low and clear_counts is ignored.
module collision_matrix
  import collision_pkg::*;
#(
  parameter int NUM_OBJ     = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  collision_matrix_if.slave bus
);

  localparam int NUM_PAIRS = num_pairs(NUM_OBJ);

  logic [NUM_PAIRS-1:0] ov;
  logic [NUM_PAIRS-1:0] seen;
  logic [NUM_PAIRS-1:0] pulse_vec;
  logic [NUM_PAIRS-1:0] frame_vec;
  logic                 collision_q;

  for (genvar i = 0; i < NUM_OBJ - 1; i++) begin : g_row
    for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_col
      localparam int K = pair_index(i, j, NUM_OBJ);

      assign ov[K] = bus.draw_requests[i] & bus.draw_requests[j] & bus.pair_mask[K];

      collision_pair_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .startOfFrame (bus.startOfFrame),
        .ov           (ov[K]),
        .hit_pulse    (pulse_vec[K]),
        .hit_frame    (frame_vec[K]),
        .seen         (seen[K])
      );
    end
  end

  // Any enabled pair overlapping at this pixel, reported one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= |ov;
  end

  assign bus.collision = collision_q;
  assign bus.hit_pulse = pulse_vec;
  assign bus.hit_frame = frame_vec;

`ifdef COLLISION_COUNT_EN
  logic [NUM_OBJ*COUNT_WIDTH-1:0] cnt_flat;

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_cnt
    localparam logic [MAX_PAIRS-1:0] OBJ_MASK = obj_pair_mask(i, NUM_OBJ);

    logic                   obj_seen;
    logic [COUNT_WIDTH-1:0] cnt;

    assign obj_seen = |(seen & OBJ_MASK[NUM_PAIRS-1:0]);

    // Frames-with-hit counter: clear wins, increments on the frame edge, saturates.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (bus.clear_counts) begin
        cnt <= '0;
      end else if (bus.startOfFrame && obj_seen && (cnt != {COUNT_WIDTH{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign cnt_flat[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt;
  end

  assign bus.obj_hit_count = cnt_flat;
`else
  logic unused_cfg;
  assign unused_cfg          = ^{bus.clear_counts, seen};
  assign bus.obj_hit_count   = '0;
`endif

endmodule

// File: tb/tb_collision_matrix.sv
// tb_collision_matrix: directed bench for collision_matrix. One 3-object
// instance (COUNT_WIDTH=2) carries most scenarios; an 8-object instance
// checks the full 28-pair fan-out and pair numbering.
module tb_collision_matrix;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  collision_matrix_if #(.NUM_OBJ(3), .COUNT_WIDTH(2)) f3 ();
  collision_matrix_if #(.NUM_OBJ(8), .COUNT_WIDTH(8)) f8 ();

  collision_matrix #(.NUM_OBJ(3), .COUNT_WIDTH(2)) d3 (.clk(clk), .rst(rst), .bus(f3.slave));
  collision_matrix #(.NUM_OBJ(8), .COUNT_WIDTH(8)) d8 (.clk(clk), .rst(rst), .bus(f8.slave));

  // Apply one cycle of inputs at a falling edge; results are visible at the next falling edge.
  task automatic cyc3(input logic sof, input logic [2:0] dr);
    f3.startOfFrame  = sof;
    f3.draw_requests = dr;
    @(negedge clk);
  endtask

  task automatic cyc8(input logic sof, input logic [7:0] dr);
    f8.startOfFrame  = sof;
    f8.draw_requests = dr;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    f3.startOfFrame = 1'b0; f3.draw_requests = '0; f3.pair_mask = 3'b111; f3.clear_counts = 1'b0;
    f8.startOfFrame = 1'b0; f8.draw_requests = '0; f8.pair_mask = '1;     f8.clear_counts = 1'b0;
    @(negedge clk); @(negedge clk);
    n_chk++; if ({f3.collision, f3.hit_pulse, f3.hit_frame} !== 7'b0) $display("FAIL reset3_out got %b exp 0", {f3.collision, f3.hit_pulse, f3.hit_frame}); else n_pass++;
    n_chk++; if (f3.obj_hit_count !== 6'b0) $display("FAIL reset3_cnt got %h exp 0", f3.obj_hit_count); else n_pass++;
    n_chk++; if ({f8.collision, f8.hit_pulse, f8.hit_frame} !== 57'b0) $display("FAIL reset8_out got %h exp 0", {f8.collision, f8.hit_pulse, f8.hit_frame}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_overlap_run;
    cyc3(1'b1, 3'b000);
    cyc3(1'b0, 3'b000);
    n_chk++; if (f3.collision !== 1'b0) $display("FAIL run_pre_coll got %b exp 0", f3.collision); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      cyc3(1'b0, 3'b011);
      n_chk++;
      if ({f3.collision, f3.hit_pulse} !== {1'b1, (c == 0) ? 3'b001 : 3'b000})
        $display("FAIL run_cyc%0d got coll=%b pulse=%b exp coll=1 pulse=%b", c, f3.collision, f3.hit_pulse, (c == 0) ? 3'b001 : 3'b000);
      else n_pass++;
    end
    cyc3(1'b0, 3'b000);
    n_chk++; if ({f3.collision, f3.hit_pulse} !== 4'b0) $display("FAIL run_after got %b exp 0", {f3.collision, f3.hit_pulse}); else n_pass++;
    n_chk++; if (f3.hit_frame !== 3'b000) $display("FAIL run_frame_pre got %b exp 000", f3.hit_frame); else n_pass++;
    cyc3(1'b1, 3'b000);
    n_chk++; if (f3.hit_frame !== 3'b001) $display("FAIL run_frame got %b exp 001", f3.hit_frame); else n_pass++;
    cyc3(1'b0, 3'b000);
    n_chk++; if (f3.hit_frame !== 3'b001) $display("FAIL run_frame_hold got %b exp 001", f3.hit_frame); else n_pass++;
  endtask

  task automatic test_mask;
    f3.pair_mask = 3'b110;
    cyc3(1'b0, 3'b011);
    n_chk++; if ({f3.collision, f3.hit_pulse} !== 4'b0000) $display("FAIL mask_off got %b exp 0000", {f3.collision, f3.hit_pulse}); else n_pass++;
    cyc3(1'b0, 3'b101);
    n_chk++; if ({f3.collision, f3.hit_pulse} !== 4'b1010) $display("FAIL mask_on got %b exp 1010", {f3.collision, f3.hit_pulse}); else n_pass++;
    // Masking pair 1 after its hit must not forget that it was already seen.
    f3.pair_mask = 3'b101;
    cyc3(1'b0, 3'b101);
    n_chk++; if ({f3.collision, f3.hit_pulse} !== 4'b0000) $display("FAIL mask_cleared got %b exp 0000", {f3.collision, f3.hit_pulse}); else n_pass++;
    f3.pair_mask = 3'b111;
    cyc3(1'b0, 3'b101);
    n_chk++; if ({f3.collision, f3.hit_pulse} !== 4'b1000) $display("FAIL mask_seen_kept got %b exp 1000", {f3.collision, f3.hit_pulse}); else n_pass++;
    cyc3(1'b0, 3'b000);
  endtask

  task automatic test_sof_overlap;
    cyc3(1'b0, 3'b110);
    n_chk++; if (f3.hit_pulse !== 3'b100) $display("FAIL sof_pre_pulse got %b exp 100", f3.hit_pulse); else n_pass++;
    cyc3(1'b0, 3'b000);
    cyc3(1'b1, 3'b110);
    n_chk++; if ({f3.collision, f3.hit_pulse, f3.hit_frame} !== 7'b1_100_110) $display("FAIL sof_edge got %b exp 1100110", {f3.collision, f3.hit_pulse, f3.hit_frame}); else n_pass++;
    cyc3(1'b0, 3'b110);
    n_chk++; if ({f3.collision, f3.hit_pulse} !== 4'b1000) $display("FAIL sof_b2b got %b exp 1000", {f3.collision, f3.hit_pulse}); else n_pass++;
    cyc3(1'b0, 3'b000);
    cyc3(1'b1, 3'b000);
    n_chk++; if (f3.hit_frame !== 3'b100) $display("FAIL sof_new_frame got %b exp 100", f3.hit_frame); else n_pass++;
    cyc3(1'b0, 3'b000);
    cyc3(1'b1, 3'b000);
    n_chk++; if (f3.hit_frame !== 3'b000) $display("FAIL sof_empty_frame got %b exp 000", f3.hit_frame); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    cyc3(1'b0, 3'b011);
    cyc3(1'b0, 3'b000);
    cyc3(1'b1, 3'b000);
    n_chk++; if (f3.hit_frame !== 3'b001) $display("FAIL rstm_frame_pre got %b exp 001", f3.hit_frame); else n_pass++;
    cyc3(1'b0, 3'b011);
    n_chk++; if ({f3.collision, f3.hit_pulse} !== 4'b1001) $display("FAIL rstm_pulse_pre got %b exp 1001", {f3.collision, f3.hit_pulse}); else n_pass++;
    f3.draw_requests = 3'b000;
    rst = 1'b1;
    #1;
    n_chk++; if ({f3.collision, f3.hit_pulse, f3.hit_frame} !== 7'b0) $display("FAIL rstm_async got %b exp 0", {f3.collision, f3.hit_pulse, f3.hit_frame}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    cyc3(1'b0, 3'b011);
    n_chk++; if (f3.hit_pulse !== 3'b001) $display("FAIL rstm_repulse got %b exp 001", f3.hit_pulse); else n_pass++;
    cyc3(1'b0, 3'b000);
    cyc3(1'b1, 3'b000);
    n_chk++; if (f3.hit_frame !== 3'b001) $display("FAIL rstm_partial_frame got %b exp 001", f3.hit_frame); else n_pass++;
`ifndef COLLISION_COUNT_EN
    n_chk++; if (f3.obj_hit_count !== 6'b0) $display("FAIL cnt_tied got %h exp 0", f3.obj_hit_count); else n_pass++;
`endif
  endtask

`ifdef COLLISION_COUNT_EN
  task automatic test_counters;
    logic [1:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int it = 0; it < 5; it++) begin
      e = (it < 3) ? 2'(it + 1) : 2'd3;
      cyc3(1'b0, 3'b011);
      cyc3(1'b0, 3'b000);
      cyc3(1'b1, 3'b000);
      n_chk++;
      if (f3.obj_hit_count !== {2'b00, e, e})
        $display("FAIL cnt_frame%0d got %h exp %h", it, f3.obj_hit_count, {2'b00, e, e});
      else n_pass++;
    end
    cyc3(1'b0, 3'b011);
    f3.clear_counts = 1'b1;
    cyc3(1'b1, 3'b000);
    f3.clear_counts = 1'b0;
    n_chk++; if (f3.obj_hit_count !== 6'b0) $display("FAIL cnt_clear got %h exp 0", f3.obj_hit_count); else n_pass++;
  endtask
`endif

  task automatic test_eight_obj;
    cyc8(1'b0, 8'hFF);
    n_chk++; if ({f8.collision, f8.hit_pulse} !== {1'b1, 28'hFFF_FFFF}) $display("FAIL all28 got %h exp 1fffffff", {f8.collision, f8.hit_pulse}); else n_pass++;
    cyc8(1'b0, 8'hFF);
    n_chk++; if ({f8.collision, f8.hit_pulse} !== {1'b1, 28'h0}) $display("FAIL all28_b2b got %h exp 10000000", {f8.collision, f8.hit_pulse}); else n_pass++;
    // Objects 2 and 5 form pair 15; the overlap lands on the frame edge.
    cyc8(1'b1, 8'h24);
    n_chk++; if (f8.hit_pulse !== 28'h000_8000) $display("FAIL pair2_5 got %h exp 0008000", f8.hit_pulse); else n_pass++;
    n_chk++; if (f8.hit_frame !== 28'hFFF_FFFF) $display("FAIL frame28 got %h exp fffffff", f8.hit_frame); else n_pass++;
    cyc8(1'b0, 8'h00);
    n_chk++; if ({f8.collision, f8.hit_pulse} !== 29'h0) $display("FAIL idle28 got %h exp 0", {f8.collision, f8.hit_pulse}); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_overlap_run();
    test_mask();
    test_sof_overlap();
    test_reset_midframe();
`ifdef COLLISION_COUNT_EN
    test_counters();
`endif
    test_eight_obj();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
